// File: rtl/mpu_pkg.sv
// Shared definitions for the mpu_core micro-sequencer: opcodes, ALU function
// codes, instruction field positions and the control FSM state type.
package mpu_pkg;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_AND = 2'b10;
    localparam logic [1:0] FN_OR  = 2'b11;

    localparam int OP_LSB  = 13;
    localparam int RD_LSB  = 10;
    localparam int RS1_LSB = 7;
    localparam int RS2_LSB = 4;
    localparam int FN_LSB  = 0;
    localparam int IMM_W   = 7;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

endpackage

// File: rtl/mpu_alu.sv
// Combinational datapath for mpu_core: add/sub/and/or plus equality compare.
// Build option MPU_CORE_MUL_EN turns function code 11 into a multiply.
module mpu_alu
    import mpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        fn,
    output logic [DATA_W-1:0] y,
    output logic              eq
);

    always_comb begin
        // NOTE: default assignment first so every path drives y and no latch is inferred.
        y = '0;
        case (fn)
            FN_ADD: y = a + b;
            FN_SUB: y = a - b;
            FN_AND: y = a & b;
            FN_OR: begin
`ifdef MPU_CORE_MUL_EN
                y = a * b;
`else
                y = a | b;
`endif
            end
            default: y = '0;
        endcase
    end

    assign eq = (a == b);

endmodule

// File: rtl/mpu_core.sv
// Multi-cycle 16-bit-instruction micro-sequencer with eight registers and
// request/ack instruction and data ports. Optional multiply: MPU_CORE_MUL_EN.
module mpu_core
    import mpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 8,
    parameter int DADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               halted,
    output logic               illegal
);

    state_t            state;
    logic [15:0]       ir;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] rf [8];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;

    logic [2:0]        op;
    logic [2:0]        rd;
    logic [2:0]        rs1;
    logic [2:0]        rs2;
    logic [1:0]        fn;
    logic [DATA_W-1:0] imm_d;
    logic [PC_W-1:0]   imm_p;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   pc_inc;

    logic [DATA_W-1:0] alu_b;
    logic [1:0]        alu_fn;
    logic [DATA_W-1:0] alu_y;
    logic              alu_eq;

    assign op     = ir[OP_LSB +: 3];
    assign rd     = ir[RD_LSB +: 3];
    assign rs1    = ir[RS1_LSB +: 3];
    assign rs2    = ir[RS2_LSB +: 3];
    assign fn     = ir[FN_LSB +: 2];
    assign imm_d  = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign imm_p  = {{(PC_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign target = ir[PC_W-1:0];
    assign pc_inc = pc + PC_W'(1);

    assign imem_addr = pc;

    // BEQ compares rd against rs1, so it shares the register operand path with R-type.
    assign alu_b  = (op == OP_R || op == OP_BEQ) ? op_b : imm_d;
    assign alu_fn = (op == OP_R) ? fn : FN_ADD;

    mpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a  (op_a),
        .b  (alu_b),
        .fn (alu_fn),
        .y  (alu_y),
        .eq (alu_eq)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= '0;
            ir         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            // NOTE: the register file is small and must read zero after reset, so it is cleared here.
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    if (op == OP_ILL) begin
                        illegal  <= 1'b1;
                        pc       <= pc_inc;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end else begin
                        op_a  <= rf[rs1];
                        op_b  <= (op == OP_R) ? rf[rs2] : rf[rd];
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (op)
                        OP_R, OP_ADDI: begin
                            result <= alu_y;
                            state  <= WB;
                        end
                        OP_LW, OP_SW: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_SW);
                            dmem_addr  <= alu_y[DADDR_W-1:0];
                            dmem_wdata <= op_b;
                            state      <= MEM;
                        end
                        OP_BEQ: begin
                            pc       <= alu_eq ? pc_inc + imm_p : pc_inc;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                        OP_JMP: begin
                            pc       <= target;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                        default: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                    endcase
                end
                MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (dmem_we) begin
                            pc       <= pc_inc;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            result <= dmem_rdata;
                            state  <= WB;
                        end
                    end
                end
                WB: begin
                    if (rd != 3'd0) rf[rd] <= result;
                    pc       <= pc_inc;
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/mpu_core.md
MPU_CORE -- requirements
Module: mpu_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning datapath and register width (legal 8..32).
REQ-002 SHALL have parameter PC_W, default 8, meaning program counter and instruction address width (legal 8..13).
REQ-003 SHALL have parameter DADDR_W, default 8, meaning data memory address width (legal 8..DATA_W).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port imem_req, output, 1 bit, instruction fetch request.
REQ-007 SHALL have port imem_addr, output, PC_W bits, fetch address (word-addressed).
REQ-008 SHALL have port imem_ack, input, 1 bit, fetch complete; imem_rdata valid the same cycle.
REQ-009 SHALL have port imem_rdata, input, 16 bits, fetched instruction.
REQ-010 SHALL have ports dmem_req/dmem_we (output, 1 bit), dmem_addr (output, DADDR_W), dmem_wdata (output, DATA_W), dmem_ack (input, 1 bit), dmem_rdata (input, DATA_W): data memory transfer.
REQ-011 SHALL have port halted, output, 1 bit, core stopped on HALT.
REQ-012 SHALL have port illegal, output, 1 bit, one-cycle pulse on an undefined encoding.

Function
REQ-013 Instruction fields SHALL be op[15:13], rd[12:10], rs1[9:7], rs2[6:4], fn[1:0], imm7[6:0] sign-extended to DATA_W, target[12:0] zero-extended/truncated to PC_W.
REQ-014 op 000 R-type SHALL compute rd = rs1 fn rs2 with fn 00 ADD, 01 SUB, 10 AND, 11 OR, wrapping modulo 2^DATA_W.
REQ-015 op 001 ADDI: rd = rs1 + imm7; op 010 LW: rd = mem[rs1+imm7]; op 011 SW: mem[rs1+imm7] = rd; addresses SHALL be the low DADDR_W bits of the sum.
REQ-016 op 100 BEQ SHALL set pc = pc+1+imm7 (modulo 2^PC_W) when rd == rs1, else pc+1; op 101 JMP: pc = target; op 110 HALT; op 111 illegal.
REQ-017 Register r0 SHALL read as zero; writes to r0 SHALL be discarded; eight registers total.
REQ-018 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-019 FETCH: assert imem_req with imem_addr = pc until imem_ack sampled high, latch instruction, go DECODE; ack in the first request cycle SHALL be accepted.
REQ-020 DECODE: read operands, go EXEC; op 111 SHALL pulse illegal, advance pc by 1, return to FETCH.
REQ-021 EXEC: ALU/ADDI go WB; LW/SW go MEM; BEQ/JMP update pc, go FETCH; HALT goes HALT.
REQ-022 MEM: hold dmem_req, dmem_we, dmem_addr, dmem_wdata stable until dmem_ack; LW goes WB latching dmem_rdata, SW goes FETCH with pc+1.
REQ-023 WB: write rd, pc = pc+1, go FETCH.
REQ-024 Minimum latency SHALL be 4 cycles R-type/ADDI, 5 LW, 4 SW, 3 BEQ/JMP with zero-wait acks; each extra ack wait cycle adds one cycle.
REQ-025 HALT state SHALL be terminal until reset, halted = 1, no requests issued.
REQ-026 imem_req and dmem_req SHALL never be high in the same cycle; acks arriving without a pending request SHALL be ignored.

Reset
REQ-027 On reset: pc = 0, all registers 0, state FETCH, imem_req/dmem_req/dmem_we/halted/illegal = 0, addresses and wdata = 0.
REQ-028 Reset asserted mid-transfer SHALL drop requests the following cycle and discard any ack received in the reset cycle; first fetch from address 0 begins the cycle after reset deasserts.

Configuration
REQ-029 Macro MPU_CORE_MUL_EN defined: R-type fn 11 SHALL be MUL, rd = low DATA_W bits of rs1*rs2, OR moves to... not available; undefined: fn 11 SHALL be OR as in REQ-014 and no multiplier SHALL be synthesised.

Structure
REQ-030 Package mpu_pkg SHALL hold opcode constants, fn codes, FSM state enum and field bit positions.
REQ-031 Arithmetic SHALL live in sub-module mpu_alu (parametrised by DATA_W, combinational, includes equality compare); register file inline.

Verification
REQ-032 reset, ADDI r1,r0,5 then ADDI r2,r0,3 then R ADD r3,r1,r2, zero-wait acks -> r3 = 8 after 12 cycles, imem_addr sequence 0,1,2.
REQ-033 DATA_W=8: ADDI r1,r0,-1 then ADD r2,r1,r1 -> r2 = 0xFE (wrap); writes to r0 leave r0 = 0.
REQ-034 SW r1 at r0+4 then LW r5 from r0+4 with dmem_ack delayed 3 cycles -> dmem_addr = 4 held 4 cycles, r5 = r1, SW total 7 cycles.
REQ-035 BEQ r1,r1,imm7=-2 at pc 10 -> next imem_addr = 9; BEQ unequal -> 11; JMP target 0x1FF with PC_W=8 -> 0xFF.
REQ-036 Fetch opcode 111 -> illegal high exactly one cycle, pc+1; then HALT -> halted = 1, no further imem_req for 20 cycles.
REQ-037 reset asserted while dmem_req high and ack arriving same cycle -> no register/pc update, dmem_req = 0 next cycle, fetch resumes at 0.
